// File: rtl/div_sub_shift.sv
// Sequential restoring (shift-subtract) unsigned divider: quotient and remainder after 2N cycles.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor finishes at once with o_dz set.
module div_sub_shift #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_st,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_idle,
  output logic         o_done,
  output logic         o_dz
);

  localparam int CW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SH   = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [N:0]    r_rem;
  logic [N-1:0]  r_q;
  logic [N-1:0]  r_d;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_quot;
  logic [N-1:0]  r_rem_out;
`ifdef DIV_ZERO_DETECT_EN
  logic          r_dz;
`endif

  logic          w_ge;
  logic [N:0]    w_rem_sub;
  logic [N-1:0]  w_q_sub;
  logic          w_last;

  // The compare is N+1 bits wide: after a shift R can exceed any N-bit divisor.
  assign w_ge      = (r_rem >= {1'b0, r_d});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_d}) : r_rem;
  assign w_q_sub   = {r_q[N-1:1], r_q[0] | w_ge};
  assign w_last    = (r_cnt == CW'(N - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_quot    <= '0;
      r_rem_out <= '0;
`ifdef DIV_ZERO_DETECT_EN
      r_dz      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_st) begin
            r_rem   <= '0;
            r_q     <= i_dividend;
            r_d     <= i_divisor;
            r_cnt   <= '0;
            r_state <= S_SH;
`ifdef DIV_ZERO_DETECT_EN
            r_dz    <= 1'b0;
            if (i_divisor == '0) begin
              r_quot    <= '1;
              r_rem_out <= i_dividend;
              r_dz      <= 1'b1;
              r_state   <= S_DONE;
            end
`endif
          end
        end
        S_SH: begin
          {r_rem, r_q} <= {r_rem[N-1:0], r_q, 1'b0};
          r_state      <= S_SUB;
        end
        S_SUB: begin
          r_rem <= w_rem_sub;
          r_q   <= w_q_sub;
          if (w_last) begin
            r_quot    <= w_q_sub;
            r_rem_out <= w_rem_sub[N-1:0];
            r_state   <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_SH;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_quotient  = r_quot;
  assign o_remainder = r_rem_out;
  assign o_idle      = (r_state == S_IDLE);
  assign o_done      = (r_state == S_DONE);
`ifdef DIV_ZERO_DETECT_EN
  assign o_dz        = r_dz;
`else
  assign o_dz        = 1'b0;
`endif

endmodule

// File: tb/tb_div_sub_shift.sv
// Scoreboard bench for div_sub_shift: expected results queued at start, checked at done.
module tb_div_sub_shift;

  localparam int N = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st = 1'b0;
  logic [N-1:0] dvd = '0;
  logic [N-1:0] dvs = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         idle;
  logic         done;
  logic         dz;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  div_sub_shift #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_st        (st),
    .i_dividend  (dvd),
    .i_divisor   (dvs),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_idle      (idle),
    .o_done      (done),
    .o_dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_expect(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.q   = (b == 0) ? {N{1'b1}} : N'(a / b);
    e.r   = (b == 0) ? a : N'(a % b);
    e.dz  = DZ_EN && (b == 0);
    e.lat = e.dz ? 0 : 2 * N;
    sb.push_back(e);
  endtask

  // Called at E0+#1 (or cyc0 cycles later); waits for done, then checks the result and the idle return.
  task automatic wait_done(input string tag, input int cyc0);
    exp_t e;
    int   cyc;
    cyc = cyc0;
    e = sb.pop_front();
    check_value({tag, "_idle_low"}, 32'(idle), 32'(0));
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_value({tag, "_timeout"}, 32'(cyc < 40), 32'(1));
    check_value({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check_value({tag, "_q"}, 32'(quotient), 32'(e.q));
    check_value({tag, "_r"}, 32'(remainder), 32'(e.r));
    check_value({tag, "_dz"}, 32'(dz), 32'(e.dz));
    $display("TXN %s: %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, e.a, e.b, quotient, remainder, dz, cyc);
    @(posedge clk);
    #1;
    check_value({tag, "_done_pulse"}, 32'(done), 32'(0));
    check_value({tag, "_idle_back"}, 32'(idle), 32'(1));
  endtask

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    dvd = a;
    dvs = b;
    st  = 1'b1;
    push_expect(a, b);
    @(posedge clk);
    #1;
    st = 1'b0;
  endtask

  initial begin
    #1;
    check_value("rst_idle", 32'(idle), 32'(1));
    check_value("rst_done", 32'(done), 32'(0));
    check_value("rst_q", 32'(quotient), 32'(0));
    check_value("rst_r", 32'(remainder), 32'(0));
    check_value("rst_dz", 32'(dz), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    start_op(8'd200, 8'd7);   wait_done("200_7", 0);
    start_op(8'd255, 8'd1);   wait_done("255_1", 0);
    start_op(8'd5,   8'd9);   wait_done("5_9", 0);
    start_op(8'd0,   8'd3);   wait_done("0_3", 0);
    start_op(8'd100, 8'd0);   wait_done("100_0", 0);
    start_op(8'd9,   8'd3);   wait_done("9_3", 0);

    repeat (3) @(posedge clk);
    #1;
    check_value("hold_q", 32'(quotient), 32'(3));
    check_value("hold_r", 32'(remainder), 32'(0));

    for (int i = 0; i < 4; i++) begin
      logic [N-1:0] a;
      logic [N-1:0] b;
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(1, 255));
      start_op(a, b);
      wait_done("rand", 0);
    end

    // Operands and st change mid-operation; the running divide must not notice.
    start_op(8'd200, 8'd7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      dvd = N'($urandom_range(0, 255));
      dvs = N'($urandom_range(0, 255));
      st  = ~st;
    end
    st = 1'b0;
    wait_done("midchg", 3);

    // st held high: one idle cycle after DONE, then a reload.
    @(negedge clk);
    dvd = 8'd12;
    dvs = 8'd5;
    st  = 1'b1;
    push_expect(8'd12, 8'd5);
    @(posedge clk);
    #1;
    wait_done("held1", 0);
    push_expect(8'd12, 8'd5);
    @(posedge clk);
    #1;
    st = 1'b0;
    wait_done("held2", 0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    dvd = 8'd200;
    dvs = 8'd7;
    st  = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("arst_idle", 32'(idle), 32'(1));
    check_value("arst_done", 32'(done), 32'(0));
    check_value("arst_q", 32'(quotient), 32'(0));
    check_value("arst_r", 32'(remainder), 32'(0));
    check_value("arst_dz", 32'(dz), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'd200, 8'd7);   wait_done("post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
